// File: rtl/set_datapath.sv
// SET datapath: latches two circles and a set mode, scans the 8x8 grid PTS_PER_CYC points per acc_en step.
// Latency: two-stage pipeline, so a count lands in the accumulator one acc_en step after evaluation (16 + 1 steps per scan).
// Backpressure: acc_en_i low stalls both stages with no loss; clear_i > acc_clear_i > acc_en_i.
module set_datapath #(
    parameter int GRID_W      = 4,
    parameter int PTS_PER_CYC = 4,
    parameter int CNT_W       = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*GRID_W-1:0]   central_i,
    input  logic [2*GRID_W-1:0]   radius_i,
    input  logic [1:0]            mode_i,
    input  logic                  buffer_en_i,
    input  logic                  acc_clear_i,
    input  logic                  acc_en_i,
    input  logic                  clear_i,
    output logic [CNT_W-1:0]      candidate_o,
    output logic                  scan_done_o
);

    localparam int STEPS_PER_ROW = 8 / PTS_PER_CYC;
    localparam int STEPS         = 8 * STEPS_PER_ROW;
    localparam int IDX_W         = $clog2(STEPS + 1);
    localparam int PC_W          = $clog2(PTS_PER_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(STEPS);

    logic [GRID_W-1:0] xa_q, ya_q, xb_q, yb_q, ra_q, rb_q;
    logic [1:0]        mode_q;

    logic [IDX_W-1:0]  idx;
    logic [PC_W-1:0]   pipe_cnt;
    logic              pipe_vld;
    logic [CNT_W-1:0]  acc;

    logic [PC_W-1:0]   hit_cnt;
    logic [GRID_W-1:0] x_pt, y_pt;
    logic              in_a, in_b, hit;

    // Distance is taken as |dx|,|dy| so squares stay unsigned; same result as the signed form.
    function automatic logic in_circle(
        input logic [GRID_W-1:0] px,
        input logic [GRID_W-1:0] py,
        input logic [GRID_W-1:0] cx,
        input logic [GRID_W-1:0] cy,
        input logic [GRID_W-1:0] r
    );
        logic [GRID_W-1:0]   adx, ady;
        logic [2*GRID_W-1:0] sx, sy, r2;
        logic [2*GRID_W:0]   d2;
        adx = (px >= cx) ? px - cx : cx - px;
        ady = (py >= cy) ? py - cy : cy - py;
        sx  = {{GRID_W{1'b0}}, adx} * {{GRID_W{1'b0}}, adx};
        sy  = {{GRID_W{1'b0}}, ady} * {{GRID_W{1'b0}}, ady};
        r2  = {{GRID_W{1'b0}}, r} * {{GRID_W{1'b0}}, r};
        d2  = {1'b0, sx} + {1'b0, sy};
        return d2 <= {1'b0, r2};
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xa_q   <= '0;
            ya_q   <= '0;
            xb_q   <= '0;
            yb_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            mode_q <= '0;
        end else if (buffer_en_i) begin
            {xa_q, ya_q, xb_q, yb_q} <= central_i;
            {ra_q, rb_q}             <= radius_i;
            mode_q                   <= mode_i;
        end
    end

    always_comb begin
        hit_cnt = '0;
        x_pt    = '0;
        in_a    = 1'b0;
        in_b    = 1'b0;
        hit     = 1'b0;
        y_pt    = GRID_W'(int'(idx) / STEPS_PER_ROW + 1);
        for (int k = 0; k < PTS_PER_CYC; k++) begin
            x_pt = GRID_W'((int'(idx) % STEPS_PER_ROW) * PTS_PER_CYC + k + 1);
            in_a = in_circle(x_pt, y_pt, xa_q, ya_q, ra_q);
            in_b = in_circle(x_pt, y_pt, xb_q, yb_q, rb_q);
            case (mode_q)
                2'd0:    hit = in_a;
                2'd1:    hit = in_a & in_b;
                2'd2:    hit = in_a ^ in_b;
                default: hit = in_a | in_b;
            endcase
            hit_cnt = hit_cnt + PC_W'(hit);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx      <= '0;
            pipe_cnt <= '0;
            pipe_vld <= 1'b0;
            acc      <= '0;
        end else if (clear_i || acc_clear_i) begin
            idx      <= '0;
            pipe_cnt <= '0;
            pipe_vld <= 1'b0;
            acc      <= '0;
        end else if (acc_en_i) begin
            if (idx < IDX_DONE) begin
                pipe_cnt <= hit_cnt;
                pipe_vld <= 1'b1;
                idx      <= idx + IDX_W'(1);
            end else begin
                // idx saturates so extra acc_en steps only drain the pipeline
                pipe_vld <= 1'b0;
            end
            if (pipe_vld) begin
                acc <= acc + CNT_W'(pipe_cnt);
            end
        end
    end

    assign candidate_o = acc;
    assign scan_done_o = (idx == IDX_DONE) && !pipe_vld;

endmodule

// File: tb/tb_set_datapath.sv
// Directed bench for set_datapath: stimulus queues expected candidate/scan_done per cycle, a negedge monitor checks them.
module tb_set_datapath;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] central_i = '0;
    logic [7:0]  radius_i = '0;
    logic [1:0]  mode_i = '0;
    logic        buffer_en_i = 1'b0;
    logic        acc_clear_i = 1'b0;
    logic        acc_en_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [6:0]  candidate_o;
    logic        scan_done_o;

    set_datapath #(.GRID_W(4), .PTS_PER_CYC(4), .CNT_W(7)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .central_i   (central_i),
        .radius_i    (radius_i),
        .mode_i      (mode_i),
        .buffer_en_i (buffer_en_i),
        .acc_clear_i (acc_clear_i),
        .acc_en_i    (acc_en_i),
        .clear_i     (clear_i),
        .candidate_o (candidate_o),
        .scan_done_o (scan_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         due;
        string      name;
        logic [6:0] cand;
        logic       done;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due < cyc) begin
                errors++;
                $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.due, cyc);
            end else if (candidate_o !== e.cand || scan_done_o !== e.done) begin
                errors++;
                $display("FAIL %s: candidate_o=%0d scan_done_o=%0b, expected candidate_o=%0d scan_done_o=%0b",
                         e.name, candidate_o, scan_done_o, e.cand, e.done);
            end
        end
    end

    task automatic step(input logic be, input logic ac, input logic en, input logic cl);
        buffer_en_i = be;
        acc_clear_i = ac;
        acc_en_i    = en;
        clear_i     = cl;
        @(posedge clk_i);
        #1;
        buffer_en_i = 1'b0;
        acc_clear_i = 1'b0;
        acc_en_i    = 1'b0;
        clear_i     = 1'b0;
    endtask

    // Expected state after the most recent edge, checked at the following negedge.
    task automatic expect_now(input string name, input int cand, input logic done);
        exp_t x;
        x.due  = cyc;
        x.name = name;
        x.cand = 7'(cand);
        x.done = done;
        q.push_back(x);
    endtask

    task automatic load(input logic [3:0] xa, input logic [3:0] ya, input logic [3:0] ra,
                        input logic [3:0] xb, input logic [3:0] yb, input logic [3:0] rb,
                        input logic [1:0] m);
        central_i = {xa, ya, xb, yb};
        radius_i  = {ra, rb};
        mode_i    = m;
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic scan(input int n);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (n) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk_i);
        #1;
        expect_now("reset_state", 0, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        load(4'd4, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_now("after_acc_clear", 0, 1'b0);
        repeat (16) step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("circle_r2_16en", 13, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("circle_r2_final", 13, 1'b1);

        load(4'd4, 4'd4, 4'd2, 4'd5, 4'd4, 4'd2, 2'd1);
        scan(17);
        expect_now("mode_and", 8, 1'b1);
        load(4'd4, 4'd4, 4'd2, 4'd5, 4'd4, 4'd2, 2'd2);
        scan(17);
        expect_now("mode_xor", 10, 1'b1);
        load(4'd4, 4'd4, 4'd2, 4'd5, 4'd4, 4'd2, 2'd3);
        scan(17);
        expect_now("mode_or", 18, 1'b1);

        load(4'd4, 4'd4, 4'd15, 4'd0, 4'd0, 4'd0, 2'd0);
        scan(16);
        expect_now("full_grid_16en", 60, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("full_grid_17en", 64, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("full_grid_18en_saturate", 64, 1'b1);

        load(4'd3, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        scan(17);
        expect_now("radius_zero", 1, 1'b1);
        load(4'd0, 4'd4, 4'd1, 4'd0, 4'd0, 4'd0, 2'd0);
        scan(17);
        expect_now("centre_x0_offgrid", 1, 1'b1);
        load(4'd9, 4'd9, 4'd2, 4'd0, 4'd0, 4'd0, 2'd0);
        scan(17);
        expect_now("centre_99_offgrid", 1, 1'b1);

        // Stall while the pipeline holds the (1,2) hit that has not reached acc yet.
        load(4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 2'd0);
        scan(3);
        expect_now("stall_before", 2, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_now("stall_hold", 2, 1'b0);
        repeat (14) step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("stall_final", 3, 1'b1);

        scan(16);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        expect_now("clear_over_acc_en", 0, 1'b0);
        scan(7);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_now("acc_clear_mid_scan", 0, 1'b0);
        repeat (17) step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("restart_final", 3, 1'b1);

        load(4'd4, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 2'd0);
        scan(10);
        #2;
        rst_i = 1'b1;
        expect_now("async_reset", 0, 1'b0);
        #2;
        rst_i = 1'b0;
        scan(17);
        expect_now("config_cleared_by_reset", 0, 1'b1);
        load(4'd4, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 2'd0);
        scan(17);
        expect_now("rerun_after_reset", 13, 1'b1);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expected results never checked, required 0", q.size());
            errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
